// File: rtl/prime_collector_if.sv
// Result-stream bundle between the prime-search engine, this collector and its reader.
// Signals: NumMax/NumberChecked/Prime/PopReq toward the collector; FIFO head, count and status flags back.
// With GAP_TRACK_EN defined the bundle also carries MaxGap.
interface prime_collector_if #(
   parameter int NUM_W = 10,
   parameter int CNT_W = 8
);
   logic [NUM_W-1:0] NumMax;
   logic [NUM_W-1:0] NumberChecked;
   logic             Prime;
   logic             PopReq;
   logic [NUM_W-1:0] PrimeOut;
   logic             PrimeOutValid;
   logic [CNT_W-1:0] PrimeCount;
   logic             FifoFull;
   logic             Overflow;
   logic             OrderError;
   logic             Done;
`ifdef GAP_TRACK_EN
   logic [NUM_W-1:0] MaxGap;

   modport master (
      output NumMax, NumberChecked, Prime, PopReq,
      input  PrimeOut, PrimeOutValid, PrimeCount,
      input  FifoFull, Overflow, OrderError, Done, MaxGap
   );
   modport slave (
      input  NumMax, NumberChecked, Prime, PopReq,
      output PrimeOut, PrimeOutValid, PrimeCount,
      output FifoFull, Overflow, OrderError, Done, MaxGap
   );
`else
   modport master (
      output NumMax, NumberChecked, Prime, PopReq,
      input  PrimeOut, PrimeOutValid, PrimeCount,
      input  FifoFull, Overflow, OrderError, Done
   );
   modport slave (
      input  NumMax, NumberChecked, Prime, PopReq,
      output PrimeOut, PrimeOutValid, PrimeCount,
      output FifoFull, Overflow, OrderError, Done
   );
`endif
endinterface

// File: rtl/prime_collector.sv
// Collects primes from the engine result stream into a FWFT FIFO, counts them, flags faults.
// Ports: SysClk, Reset (sync, active high), bus (prime_collector_if.slave). Option: GAP_TRACK_EN adds MaxGap.
module prime_collector #(
   parameter int NUM_W  = 10,
   parameter int CNT_W  = 8,
   parameter int DEPTH  = 256,
   parameter int SETTLE = 2
) (
   input logic              SysClk,
   input logic              Reset,
   prime_collector_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

   localparam logic [1:0] ST_WAIT   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic [NUM_W-1:0] last_checked;
   logic [NUM_W-1:0] last_captured;
   logic             done;
   logic             order_err;
   logic             overflow;
   logic             fifo_full;
   logic [CNT_W-1:0] prime_count;

   logic [NUM_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;
   logic [AW:0]      occ_nxt;

   logic changed;
   logic capture;
   logic order_bad;
   logic hit;
   logic pop;
   logic full_now;
   logic wr_en;

   always_comb begin
      changed   = bus.NumberChecked != last_checked;
      capture   = (state == ST_SETTLE) && !changed && (cnt == 4'd0);
      order_bad = capture && (last_checked <= last_captured)
                  && (last_captured != '0);
      hit       = capture && !order_bad && bus.Prime;
      pop       = bus.PopReq && (occ != '0);
      full_now  = occ == FULL_OCC;
      // A push into a full FIFO is fine when the head leaves on the same edge.
      wr_en     = hit && (!full_now || pop);
      occ_nxt   = occ;
      unique case ({wr_en, pop})
         2'b10:   occ_nxt = occ + 1'b1;
         2'b01:   occ_nxt = occ - 1'b1;
         default: occ_nxt = occ;
      endcase
   end

   always_ff @(posedge SysClk) begin
      if (Reset) begin
         state         <= ST_WAIT;
         cnt           <= 4'd0;
         last_checked  <= '0;
         last_captured <= '0;
         done          <= 1'b0;
         order_err     <= 1'b0;
      end else begin
         unique case (state)
            ST_WAIT: begin
               if (changed) begin
                  last_checked <= bus.NumberChecked;
                  cnt          <= SETTLE_LD;
                  state        <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (changed) begin
                  // Engine moved on before the verdict settled: follow it.
                  last_checked <= bus.NumberChecked;
                  cnt          <= SETTLE_LD;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  last_captured <= last_checked;
                  if (order_bad)
                     order_err <= 1'b1;
                  if (last_checked >= bus.NumMax) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_WAIT;
         endcase
      end
   end

   always_ff @(posedge SysClk) begin
      if (Reset) begin
         prime_count <= '0;
         overflow    <= 1'b0;
         fifo_full   <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
      end else begin
         if (hit && (prime_count != '1))
            prime_count <= prime_count + 1'b1;
         if (hit && full_now && !pop)
            overflow <= 1'b1;
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         occ       <= occ_nxt;
         fifo_full <= occ_nxt == FULL_OCC;
      end
   end

   always_ff @(posedge SysClk) begin
      if (wr_en)
         mem[wr_ptr] <= last_checked;
   end

`ifdef GAP_TRACK_EN
   logic [NUM_W-1:0] last_prime;
   logic             have_prime;
   logic [NUM_W-1:0] max_gap;
   logic [NUM_W-1:0] gap;

   assign gap = last_checked - last_prime;

   // Dropped primes still advance last_prime so gaps stay between true neighbours.
   always_ff @(posedge SysClk) begin
      if (Reset) begin
         last_prime <= '0;
         have_prime <= 1'b0;
         max_gap    <= '0;
      end else if (hit) begin
         last_prime <= last_checked;
         have_prime <= 1'b1;
         if (have_prime && (gap > max_gap))
            max_gap <= gap;
      end
   end

   assign bus.MaxGap = max_gap;
`endif

   assign bus.PrimeOut      = (occ != '0) ? mem[rd_ptr] : '0;
   assign bus.PrimeOutValid = occ != '0;
   assign bus.PrimeCount    = prime_count;
   assign bus.FifoFull      = fifo_full;
   assign bus.Overflow      = overflow;
   assign bus.OrderError    = order_err;
   assign bus.Done          = done;
endmodule

// File: tb/tb_prime_collector.sv
// Self-checking bench for prime_collector: a default-depth and a DEPTH=4 instance.
// Table-driven engine run plus hand sequences; popped FIFO heads are scoreboarded.
module tb_prime_collector;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   qb[$];
   int   qs[$];
   int   eb;
   int   es;

   always #5 clk = ~clk;

   prime_collector_if #(.NUM_W(10), .CNT_W(8)) bb ();
   prime_collector_if #(.NUM_W(10), .CNT_W(8)) ss ();

   prime_collector #(.DEPTH(256)) u_big (
      .SysClk (clk),
      .Reset  (rst),
      .bus    (bb)
   );

   prime_collector #(.DEPTH(4)) u_small (
      .SysClk (clk),
      .Reset  (rst),
      .bus    (ss)
   );

   typedef struct {
      int num;
      bit prime;
      int cnt;
   } vec_t;

   vec_t tbl[20];

   function automatic bit is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++)
         if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bb.PopReq && bb.PrimeOutValid) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL big_pop: got %0d expected none", bb.PrimeOut);
         end else begin
            eb = qb.pop_front();
            if (int'(bb.PrimeOut) != eb) begin
               errors++;
               $display("FAIL big_pop: got %0d expected %0d", bb.PrimeOut, eb);
            end
         end
      end
      if (ss.PopReq && ss.PrimeOutValid) begin
         checks++;
         if (qs.size() == 0) begin
            errors++;
            $display("FAIL small_pop: got %0d expected none", ss.PrimeOut);
         end else begin
            es = qs.pop_front();
            if (int'(ss.PrimeOut) != es) begin
               errors++;
               $display("FAIL small_pop: got %0d expected %0d", ss.PrimeOut, es);
            end
         end
      end
   end

   task automatic do_reset();
      bb.NumberChecked = '0;
      bb.Prime         = 1'b0;
      bb.PopReq        = 1'b0;
      ss.NumberChecked = '0;
      ss.Prime         = 1'b0;
      ss.PopReq        = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      qb.delete();
      qs.delete();
   endtask

   task automatic drive_big(input int n, input bit p);
      bb.NumberChecked = 10'(n);
      bb.Prime         = p;
      if (p) qb.push_back(n);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic drive_small(input int n, input bit store);
      ss.NumberChecked = 10'(n);
      ss.Prime         = 1'b1;
      if (store) qs.push_back(n);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag, input int v, input int d,
                             input int c, input int f, input int o,
                             input int e, input int dn);
      chk({tag, "_valid"}, v, 0);
      chk({tag, "_data"}, d, 0);
      chk({tag, "_count"}, c, 0);
      chk({tag, "_full"}, f, 0);
      chk({tag, "_ovf"}, o, 0);
      chk({tag, "_orderr"}, e, 0);
      chk({tag, "_done"}, dn, 0);
   endtask

   initial begin
      int c;
      bb.NumMax = 10'd20;
      ss.NumMax = 10'd1000;
      c = 0;
      for (int i = 0; i < 20; i++) begin
         tbl[i].num   = i + 1;
         tbl[i].prime = is_prime(i + 1);
         if (tbl[i].prime) c++;
         tbl[i].cnt = c;
      end

      do_reset();
      check_zero("rst_big", bb.PrimeOutValid, bb.PrimeOut, bb.PrimeCount,
                 bb.FifoFull, bb.Overflow, bb.OrderError, bb.Done);
      check_zero("rst_small", ss.PrimeOutValid, ss.PrimeOut, ss.PrimeCount,
                 ss.FifoFull, ss.Overflow, ss.OrderError, ss.Done);

      // Engine run 1..20 with the reader always popping.
      bb.PopReq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive_big(tbl[i].num, tbl[i].prime);
         chk($sformatf("run_count_%0d", tbl[i].num), bb.PrimeCount, tbl[i].cnt);
         chk($sformatf("run_done_%0d", tbl[i].num), bb.Done,
             (tbl[i].num >= 20) ? 1 : 0);
      end
      chk("run_orderr", bb.OrderError, 0);
      drive_big(23, 1'b1);
      void'(qb.pop_back());
      chk("done_ignores_count", bb.PrimeCount, 8);
      chk("run_drained", qb.size(), 0);
      chk("run_valid", bb.PrimeOutValid, 0);

      // 7 replaced by 8 before it settles.
      do_reset();
      bb.NumberChecked = 10'd7;
      bb.Prime         = 1'b1;
      @(posedge clk);
      #1;
      bb.NumberChecked = 10'd8;
      bb.Prime         = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("restart_count", bb.PrimeCount, 0);
      chk("restart_valid", bb.PrimeOutValid, 0);
      chk("restart_orderr", bb.OrderError, 0);

      // 5, 9, 6: 6 is out of order.
      do_reset();
      bb.PopReq = 1'b1;
      drive_big(5, 1'b1);
      drive_big(9, 1'b0);
      bb.NumberChecked = 10'd6;
      bb.Prime         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("order_before", bb.OrderError, 0);
      @(posedge clk);
      #1;
      chk("order_at_capture", bb.OrderError, 1);
      chk("order_count", bb.PrimeCount, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("order_valid", bb.PrimeOutValid, 0);
      chk("order_q", qb.size(), 0);

      // DEPTH=4, no pops: fill then overflow.
      do_reset();
      drive_small(2, 1'b1);
      drive_small(3, 1'b1);
      drive_small(5, 1'b1);
      chk("fill3_full", ss.FifoFull, 0);
      drive_small(7, 1'b1);
      chk("fill4_full", ss.FifoFull, 1);
      chk("fill4_ovf", ss.Overflow, 0);
      drive_small(11, 1'b0);
      chk("ovf_flag", ss.Overflow, 1);
      chk("ovf_count", ss.PrimeCount, 5);
      chk("ovf_full", ss.FifoFull, 1);
      ss.PopReq = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      ss.PopReq = 1'b0;
      chk("ovf_drained", qs.size(), 0);
      chk("ovf_valid", ss.PrimeOutValid, 0);

      // Full FIFO with a pop on 13's capture edge.
      do_reset();
      drive_small(2, 1'b1);
      drive_small(3, 1'b1);
      drive_small(5, 1'b1);
      drive_small(7, 1'b1);
      ss.NumberChecked = 10'd13;
      ss.Prime         = 1'b1;
      qs.push_back(13);
      repeat (2) @(posedge clk);
      #1;
      ss.PopReq = 1'b1;
      @(posedge clk);
      #1;
      ss.PopReq = 1'b0;
      chk("pushpop_full", ss.FifoFull, 1);
      chk("pushpop_ovf", ss.Overflow, 0);
      chk("pushpop_count", ss.PrimeCount, 5);
      ss.PopReq = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      ss.PopReq = 1'b0;
      chk("pushpop_drained", qs.size(), 0);
      chk("pushpop_valid", ss.PrimeOutValid, 0);

      // Refill, overflow once, then reset mid-settle.
      drive_small(17, 1'b1);
      drive_small(19, 1'b1);
      drive_small(23, 1'b1);
      drive_small(29, 1'b1);
      drive_small(31, 1'b0);
      chk("pre_rst_full", ss.FifoFull, 1);
      chk("pre_rst_ovf", ss.Overflow, 1);
      ss.NumberChecked = 10'd37;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_zero("midrst", ss.PrimeOutValid, ss.PrimeOut, ss.PrimeCount,
                 ss.FifoFull, ss.Overflow, ss.OrderError, ss.Done);
      qs.delete();
      do_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
